vedic_mac_accum: RTL and testbench

- Multiply-accumulate back end placed directly downstream of the 8x8 Vedic multiplier.
- Consumes the 16-bit unsigned product stream and sums products over a frame (dot product) into a saturating accumulator.
- Presents the frame result, term count and status flags through a valid/ready output handshake.
- Throttles the upstream operand source with in_ready while a result is waiting to be taken.

---
 rtl/vedic_mac_accum.sv | 136 +++++++++++++
 tb/tb_vedic_mac_accum.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vedic_mac_accum.sv
// Saturating dot-product accumulator behind the 8x8 Vedic multiplier.
// Sums one frame of 16-bit products and holds the result under a valid/ready handshake.
module vedic_mac_accum #(
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_TERMS = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_product,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_trunc
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_sat_q, out_sat_d;
  logic               out_trunc_q, out_trunc_d;

  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_upd;
  logic               sat_upd;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               limit_hit;

  // Datapath for a single accepted beat; the carry bit flags saturation.
  always_comb begin
    accept    = in_valid && (state_q == ACCUM);
    sum       = {1'b0, acc_q} + (ACC_W+1)'(in_product);
    acc_upd   = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    sat_upd   = sat_q | sum[ACC_W];
    cnt_inc   = cnt_q + CNT_W'(1);
    limit_hit = (cnt_inc == CNT_W'(MAX_TERMS));
  end

  // Next-state and output-register logic; clr overrides everything but rst.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    out_trunc_d = out_trunc_q;

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = acc_upd;
          cnt_d = cnt_inc;
          sat_d = sat_upd;
          if (in_last || limit_hit) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_acc_d   = acc_upd;
            out_count_d = cnt_inc;
            out_sat_d   = sat_upd;
            out_trunc_d = !in_last;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = ACCUM;
          out_valid_d = 1'b0;
          acc_d       = '0;
          cnt_d       = '0;
          sat_d       = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (clr) begin
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      out_acc_d   = '0;
      out_count_d = '0;
      out_sat_d   = 1'b0;
      out_trunc_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_vedic_mac_accum.sv
// Bench for vedic_mac_accum: default instance plus a MAX_TERMS=4 instance,
// checked against a frame-level model (queue of products, saturating total).
module tb_vedic_mac_accum;

  localparam int unsigned ACC_W   = 20;
  localparam int unsigned CNT_W   = 8;
  localparam longint      ACC_MAX = (64'd1 << ACC_W) - 1;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, in_last, out_ready, sel;
  logic [15:0] in_product;

  logic             rdy0, rdy1, ov0, ov1, sat0, sat1, tr0, tr1;
  logic [ACC_W-1:0] acc0, acc1;
  logic [CNT_W-1:0] cnt0, cnt1;

  always #5 clk = ~clk;

  vedic_mac_accum u0 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid & ~sel), .in_ready(rdy0),
    .in_product(in_product), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .out_acc(acc0), .out_count(cnt0), .out_sat(sat0), .out_trunc(tr0)
  );

  vedic_mac_accum #(.MAX_TERMS(4)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid & sel), .in_ready(rdy1),
    .in_product(in_product), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .out_acc(acc1), .out_count(cnt1), .out_sat(sat1), .out_trunc(tr1)
  );

  wire             o_ready = sel ? rdy1 : rdy0;
  wire             o_valid = sel ? ov1  : ov0;
  wire [ACC_W-1:0] o_acc   = sel ? acc1 : acc0;
  wire [CNT_W-1:0] o_cnt   = sel ? cnt1 : cnt0;
  wire             o_sat   = sel ? sat1 : sat0;
  wire             o_trunc = sel ? tr1  : tr0;

  int passed = 0;
  int total  = 0;

  // Frame-level reference state
  longint frame_q[$];
  bit     busy;
  longint exp_acc, exp_cnt;
  bit     exp_sat, exp_trunc;
  int     lim;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(o_valid), 32'(busy));
    chk({tag, ".out_acc"},   32'(o_acc),   32'(exp_acc));
    chk({tag, ".out_count"}, 32'(o_cnt),   32'(exp_cnt));
    chk({tag, ".out_sat"},   32'(o_sat),   32'(exp_sat));
    chk({tag, ".out_trunc"}, 32'(o_trunc), 32'(exp_trunc));
  endtask

  task automatic model_clear();
    frame_q.delete();
    busy = 0; exp_acc = 0; exp_cnt = 0; exp_sat = 0; exp_trunc = 0;
  endtask

  task automatic do_reset(input string tag, input logic with_clr);
    rst = 1'b1; clr = with_clr; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; clr = 1'b0;
    model_clear();
    chk({tag, ".in_ready"}, 32'(o_ready), 32'd1);
    chk_outputs(tag);
  endtask

  // One clock of stimulus; the model decides what the DUT must do on this edge.
  task automatic cycle(input string tag, input logic v, input logic [15:0] p,
                       input logic last, input logic ordy, input logic c);
    longint tot;
    in_valid = v; in_product = p; in_last = last; out_ready = ordy; clr = c;
    chk({tag, ".in_ready"}, 32'(o_ready), 32'(!busy));
    if (c) begin
      model_clear();
    end else if (busy) begin
      if (ordy) begin
        busy = 0;
        frame_q.delete();
      end
    end else if (v) begin
      frame_q.push_back(longint'(p));
      if (last || frame_q.size() == lim) begin
        tot = 0;
        foreach (frame_q[i]) tot += frame_q[i];
        busy      = 1;
        exp_acc   = (tot > ACC_MAX) ? ACC_MAX : tot;
        exp_sat   = (tot > ACC_MAX);
        exp_cnt   = frame_q.size();
        exp_trunc = !last;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; out_ready = 1'b0;
    chk_outputs(tag);
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_product = '0; sel = 1'b0; lim = 255;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset", 1'b0);

    // Two-beat frame with out_ready held high
    cycle("two.b0", 1, 16'd38000, 0, 1, 0);
    cycle("two.b1", 1, 16'd12816, 1, 1, 0);
    cycle("two.take", 0, 16'd0, 0, 1, 0);
    cycle("two.idle", 0, 16'd0, 0, 1, 0);

    // Saturation boundary: 16 beats fit, 17 saturate
    for (int i = 0; i < 16; i++) cycle("sat16", 1, 16'd65025, (i == 15), 0, 0);
    cycle("sat16.take", 0, 16'd0, 0, 1, 0);
    for (int i = 0; i < 17; i++) cycle("sat17", 1, 16'd65025, (i == 16), 0, 0);
    cycle("sat17.take", 0, 16'd0, 0, 1, 0);

    // Backpressure: result held, beats ignored, next frame starts from zero
    cycle("bp.beat", 1, 16'd100, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle("bp.hold", 1, 16'd555, 0, 0, 0);
    cycle("bp.take", 1, 16'd777, 1, 1, 0);
    cycle("bp.next", 1, 16'd3, 1, 0, 0);
    cycle("bp.take2", 0, 16'd0, 0, 1, 0);

    // Abort mid-frame, then clr while a result is pending
    for (int i = 0; i < 3; i++) cycle("abort.acc", 1, 16'd1000, 0, 0, 0);
    cycle("abort.clr", 0, 16'd0, 0, 0, 1);
    cycle("abort.one", 1, 16'd5, 1, 0, 0);
    cycle("abort.hold", 0, 16'd0, 0, 0, 0);
    cycle("abort.clrdone", 0, 16'd0, 0, 0, 1);

    // Reset in accumulation, in DONE, and together with clr
    cycle("rst.acc", 1, 16'd4321, 0, 0, 0);
    do_reset("rst.midframe", 1'b0);
    cycle("rst.one", 1, 16'd9, 1, 0, 0);
    do_reset("rst.done", 1'b0);
    cycle("rst.two", 1, 16'd11, 1, 0, 0);
    do_reset("rst.withclr", 1'b1);

    // MAX_TERMS=4 instance: truncated frame then a normal one
    sel = 1'b1; lim = 4;
    do_reset("mt.reset", 1'b0);
    for (int i = 0; i < 4; i++) cycle("mt.trunc", 1, 16'd10, 0, 0, 0);
    cycle("mt.take", 0, 16'd0, 0, 1, 0);
    cycle("mt.seven", 1, 16'd7, 1, 0, 0);
    cycle("mt.take2", 0, 16'd0, 0, 1, 0);
    for (int i = 0; i < 4; i++) cycle("mt.lastlim", 1, 16'd2, (i == 3), 0, 0);
    cycle("mt.take3", 0, 16'd0, 0, 1, 0);

    // Randomized traffic on both instances
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1); lim = (s == 1) ? 4 : 255;
      do_reset("rnd.reset", 1'b0);
      for (int i = 0; i < 400; i++) begin
        logic [15:0] p;
        p = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
        cycle("rnd", 1'($urandom_range(0, 3) != 0), p,
              1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 59) == 0));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
